// File: rtl/apb_rx_fifo_slave_if.sv
// APB register-bus signals for the UART receive FIFO slave.
// Zero-wait-state APB: psel&&!penable is the setup phase; prdata/pslverr are valid in the access phase.
interface apb_rx_fifo_slave_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pslverr);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pslverr);
endinterface

// File: rtl/apb_rx_fifo_slave.sv
// APB slave for the UART receiver: receive FIFO, sticky W1C error flags,
// level interrupt and frame-size / bit-period configuration registers.
module apb_rx_fifo_slave #(
  parameter int FIFO_DEPTH = 4,
  parameter int BP_WIDTH   = 14
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [7:0]          rx_data,
  input  logic                data_ready,
  input  logic                overrun_error,
  input  logic                framing_error,
  output logic                data_read,
  apb_rx_fifo_slave_if.slave  apb,
  output logic [3:0]          data_size,
  output logic [BP_WIDTH-1:0] bit_period,
  output logic                rx_irq
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [1:0]    err;

  logic          full, empty, setup, wr_en, rd_en, push, pop, size_ok, bus_err;
  logic [3:0]    shamt;
  logic [7:0]    push_byte, rd_mux;
  logic [1:0]    err_clr;
  logic [15:0]   bp_ext;

  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign setup     = apb.psel & ~apb.penable;
  assign wr_en     = setup & apb.pwrite;
  assign rd_en     = setup & ~apb.pwrite;
  assign pop       = rd_en && (apb.paddr == 3'd6) && !empty;
  // data_read blocks a second push while the receiver is still dropping data_ready
  assign push      = data_ready && !full && !data_read;
  assign shamt     = 4'd8 - data_size;
  assign push_byte = rx_data >> shamt;
  assign size_ok   = (apb.pwdata >= 8'd5) && (apb.pwdata <= 8'd8);
  assign err_clr   = (wr_en && apb.paddr == 3'd1) ? apb.pwdata[1:0] : 2'b00;
  assign bp_ext    = 16'(bit_period);

  always_comb begin
    rd_mux = 8'h00;
    case (apb.paddr)
      3'd0: rd_mux = {5'b0, full, |err, !empty};
      3'd1: rd_mux = {6'b0, err};
      3'd2: rd_mux = bit_period[7:0];
      3'd3: rd_mux = bp_ext[15:8];
      3'd4: rd_mux = {4'b0, data_size};
      3'd5: rd_mux = 8'(count);
      3'd6: rd_mux = empty ? 8'h00 : mem[rd_ptr];
      default: rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    bus_err = 1'b0;
    if (apb.pwrite) begin
      case (apb.paddr)
        3'd0, 3'd5, 3'd6, 3'd7: bus_err = 1'b1;
        3'd4:                   bus_err = !size_ok;
        default:                bus_err = 1'b0;
      endcase
    end else begin
      bus_err = (apb.paddr == 3'd7) || (apb.paddr == 3'd6 && empty);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err         <= 2'b00;
      data_read   <= 1'b0;
      rx_irq      <= 1'b0;
      apb.prdata  <= 8'h00;
      apb.pslverr <= 1'b0;
      data_size   <= 4'd8;
      bit_period  <= BP_WIDTH'(10);
    end else begin
      data_read <= push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      // a new error in the same cycle as its W1C clear leaves the bit set
      err    <= (err & ~err_clr) | {overrun_error, framing_error};
      rx_irq <= !empty | (|err);
      apb.pslverr <= setup & bus_err;
      if (rd_en) apb.prdata <= rd_mux;
      else if (wr_en && apb.paddr == 3'd7) apb.prdata <= 8'h00;
      if (wr_en) begin
        case (apb.paddr)
          3'd2: bit_period[7:0] <= apb.pwdata;
          3'd3: bit_period[BP_WIDTH-1:8] <= apb.pwdata[BP_WIDTH-9:0];
          3'd4: if (size_ok) data_size <= apb.pwdata[3:0];
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_apb_rx_fifo_slave.sv
// Self-checking bench for apb_rx_fifo_slave: reset table, directed corner sequences,
// then randomized traffic compared against a queue-based register model.
module tb_apb_rx_fifo_slave;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        data_ready = 1'b0, overrun_error = 1'b0, framing_error = 1'b0;
  logic        data_read, rx_irq;
  logic [3:0]  data_size;
  logic [13:0] bit_period;

  apb_rx_fifo_slave_if bus();

  apb_rx_fifo_slave #(.FIFO_DEPTH(DEPTH), .BP_WIDTH(14)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .data_ready(data_ready),
    .overrun_error(overrun_error), .framing_error(framing_error),
    .data_read(data_read), .apb(bus), .data_size(data_size),
    .bit_period(bit_period), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0]  exp_q[$];
  logic [1:0]  m_err;
  logic [3:0]  m_size;
  logic [13:0] m_bp;

  typedef struct { logic [2:0] addr; logic [7:0] data; logic err; } rd_vec_t;
  rd_vec_t rst_tab[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d, output logic e);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    d = bus.prdata; e = bus.pslverr;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [7:0] wd, input logic ovr, output logic e);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = wd;
    overrun_error = ovr;
    @(posedge clk); #1;
    overrun_error = 1'b0;
    bus.penable = 1'b1;
    e = bus.pslverr;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, output logic accepted);
    accepted = 1'b0;
    rx_data = d; data_ready = 1'b1;
    for (int i = 0; i < 8 && !accepted; i++) begin
      @(posedge clk); #1;
      if (data_read) accepted = 1'b1;
    end
    data_ready = 1'b0;
  endtask

  task automatic pulse_err(input logic f, input logic o);
    @(posedge clk); #1;
    framing_error = f; overrun_error = o;
    @(posedge clk); #1;
    framing_error = 1'b0; overrun_error = 1'b0;
  endtask

  function automatic logic [8:0] model_read(input logic [2:0] a);
    logic [7:0] d;
    logic e;
    e = 1'b0;
    case (a)
      3'd0: d = {5'b0, exp_q.size() == DEPTH, m_err != 2'b00, exp_q.size() != 0};
      3'd1: d = {6'b0, m_err};
      3'd2: d = m_bp[7:0];
      3'd3: d = {2'b0, m_bp[13:8]};
      3'd4: d = {4'b0, m_size};
      3'd5: d = 8'(exp_q.size());
      3'd6: begin
        if (exp_q.size() == 0) begin d = 8'h00; e = 1'b1; end
        else d = exp_q[0];
      end
      default: begin d = 8'h00; e = 1'b1; end
    endcase
    return {e, d};
  endfunction

  initial begin
    logic [7:0] d;
    logic e, acc, seen;
    logic [8:0] r;

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 3'd0; bus.pwdata = 8'h00;

    rst_tab[0] = '{3'd0, 8'h00, 1'b0};
    rst_tab[1] = '{3'd1, 8'h00, 1'b0};
    rst_tab[2] = '{3'd2, 8'h0A, 1'b0};
    rst_tab[3] = '{3'd3, 8'h00, 1'b0};
    rst_tab[4] = '{3'd4, 8'h08, 1'b0};
    rst_tab[5] = '{3'd5, 8'h00, 1'b0};
    rst_tab[6] = '{3'd7, 8'h00, 1'b1};

    // clock / reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_prdata", bus.prdata, 8'h00);
    check("rst_pslverr", bus.pslverr, 1'b0);
    check("rst_data_read", data_read, 1'b0);
    check("rst_irq", rx_irq, 1'b0);
    check("rst_size", data_size, 4'd8);
    check("rst_bp", bit_period, 14'd10);
    n_rst = 1'b1;

    foreach (rst_tab[i]) begin
      apb_read(rst_tab[i].addr, d, e);
      check($sformatf("rst_read_a%0d", rst_tab[i].addr), d, rst_tab[i].data);
      check($sformatf("rst_err_a%0d", rst_tab[i].addr), e, rst_tab[i].err);
    end
    check("pslverr_idle", bus.pslverr, 1'b0);

    // 5-bit frames are right-justified on push
    apb_write(3'd4, 8'h05, 1'b0, e);
    check("size5_err", e, 1'b0);
    check("size5_out", data_size, 4'd5);
    send_frame(8'hA8, acc);
    check("push5_accept", acc, 1'b1);
    @(posedge clk); #1;
    check("push5_single_pulse", data_read, 1'b0);
    apb_read(3'd5, d, e);
    check("push5_count1", d, 8'd1);
    apb_read(3'd6, d, e);
    check("pop5_data", d, 8'h15);
    check("pop5_err", e, 1'b0);
    apb_read(3'd5, d, e);
    check("pop5_count0", d, 8'd0);

    // fill to full, extra frame stays pending until a pop frees a slot
    apb_write(3'd4, 8'h08, 1'b0, e);
    check("size8_err", e, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'(17 * (i + 1)), acc);
      check($sformatf("fill_accept_%0d", i), acc, 1'b1);
    end
    rx_data = 8'(17 * (DEPTH + 1)); data_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (data_read) seen = 1'b1;
    end
    check("full_no_accept", seen, 1'b0);
    apb_read(3'd0, d, e);
    check("full_status", d, 8'h05);
    check("full_status_err", e, 1'b0);
    apb_read(3'd6, d, e);
    check("full_pop_data", d, 8'h11);
    seen = data_read;
    for (int i = 0; i < 3 && !seen; i++) begin
      @(posedge clk); #1;
      seen = data_read;
    end
    data_ready = 1'b0;
    check("pending_accept", seen, 1'b1);
    for (int i = 1; i <= DEPTH; i++) begin
      apb_read(3'd6, d, e);
      check($sformatf("drain_%0d", i), d, 8'(17 * (i + 1)));
    end
    apb_read(3'd5, d, e);
    check("drain_count0", d, 8'd0);

    // sticky errors and W1C
    pulse_err(1'b1, 1'b1);
    apb_read(3'd1, d, e);
    check("err_both", d, 8'h03);
    check("err_irq", rx_irq, 1'b1);
    apb_write(3'd1, 8'h01, 1'b0, e);
    check("w1c_err", e, 1'b0);
    apb_read(3'd1, d, e);
    check("w1c_bit0", d, 8'h02);
    apb_write(3'd1, 8'h02, 1'b1, e);
    apb_read(3'd1, d, e);
    check("w1c_set_wins", d, 8'h02);
    apb_write(3'd1, 8'h02, 1'b0, e);
    apb_read(3'd1, d, e);
    check("w1c_clear_all", d, 8'h00);
    @(posedge clk); #1;
    check("irq_clear", rx_irq, 1'b0);

    // illegal accesses
    apb_write(3'd4, 8'h09, 1'b0, e);
    check("bad_size_err", e, 1'b1);
    check("bad_size_kept", data_size, 4'd8);
    apb_read(3'd6, d, e);
    check("empty_pop_data", d, 8'h00);
    check("empty_pop_err", e, 1'b1);
    apb_write(3'd7, 8'h5A, 1'b0, e);
    check("a7_write_err", e, 1'b1);
    apb_write(3'd0, 8'h5A, 1'b0, e);
    check("ro_write_err", e, 1'b1);
    apb_write(3'd3, 8'h34, 1'b0, e);
    check("bp_hi_err", e, 1'b0);
    check("bp_hi_out", bit_period[13:8], 6'h34);
    apb_read(3'd3, d, e);
    check("bp_hi_read", d, 8'h34);

    // randomized traffic against the model
    exp_q.delete();
    m_err = 2'b00; m_size = 4'd8; m_bp = 14'h340A;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: if (exp_q.size() < DEPTH) begin
          d = 8'($urandom_range(0, 255));
          send_frame(d, acc);
          check("rnd_accept", acc, 1'b1);
          exp_q.push_back(d >> (8 - m_size));
        end
        1: begin
          logic [2:0] a;
          a = 3'($urandom_range(0, 7));
          r = model_read(a);
          apb_read(a, d, e);
          check($sformatf("rnd_rd_a%0d", a), d, r[7:0]);
          check($sformatf("rnd_rderr_a%0d", a), e, r[8]);
          if (a == 3'd6 && exp_q.size() != 0) void'(exp_q.pop_front());
        end
        2: begin
          logic [2:0] a;
          logic [7:0] wd;
          logic xe;
          a = 3'($urandom_range(0, 7));
          wd = (a == 3'd4) ? 8'($urandom_range(3, 9)) : 8'($urandom_range(0, 255));
          xe = 1'b0;
          case (a)
            3'd1: m_err = m_err & ~wd[1:0];
            3'd2: m_bp[7:0] = wd;
            3'd3: m_bp[13:8] = wd[5:0];
            3'd4: if (wd >= 8'd5 && wd <= 8'd8) m_size = wd[3:0]; else xe = 1'b1;
            default: xe = 1'b1;
          endcase
          apb_write(a, wd, 1'b0, e);
          check($sformatf("rnd_wrerr_a%0d", a), e, xe);
          check("rnd_size", data_size, m_size);
          check("rnd_bp", bit_period, m_bp);
        end
        default: begin
          logic f, o;
          f = 1'($urandom_range(0, 1));
          o = 1'($urandom_range(0, 1));
          pulse_err(f, o);
          m_err = m_err | {o, f};
          @(posedge clk); #1;
          check("rnd_irq", rx_irq, (exp_q.size() != 0) || (m_err != 2'b00));
        end
      endcase
    end

    // asynchronous reset mid-push
    rx_data = 8'h77; data_ready = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    data_ready = 1'b0;
    check("arst_data_read", data_read, 1'b0);
    check("arst_irq", rx_irq, 1'b0);
    check("arst_size", data_size, 4'd8);
    @(posedge clk); #1;
    n_rst = 1'b1;
    apb_read(3'd5, d, e);
    check("arst_count", d, 8'd0);
    apb_read(3'd1, d, e);
    check("arst_err", d, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
